// File: rtl/gpu_foreground_line_scanner.sv
// Foreground sprite line scanner: walks the OBM once per start pulse and collects up to MaxPerLine
// objects covering the scanline into a double-buffered hit list read by the foreground pixel stage.
module gpu_foreground_line_scanner #(
   parameter int NumObjects = 64,
   parameter int MaxPerLine = 8,
   parameter int ObjHeight  = 8,
   localparam int IdxW  = $clog2(NumObjects),
   localparam int SlotW = $clog2(MaxPerLine),
   localparam int CntW  = SlotW + 1
) (
   input  logic             clk_gpu,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [7:0]       line_i,
   output logic             obm_re_o,
   output logic [IdxW-1:0]  obm_index_o,
   input  logic [31:0]      obm_object_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CntW-1:0]  hit_count_o,
   output logic             overflow_o,
   input  logic [SlotW-1:0] slot_sel_i,
   output logic [31:0]      slot_object_o,
   output logic [2:0]       slot_row_o
);

   // obm_object_t field positions used by the hit test
   localparam int YLsb     = 16;
   localparam int YMsb     = 23;
   localparam int VflipBit = 0;
   localparam int RowW     = $clog2(ObjHeight);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [IdxW-1:0]   last_idx_q, last_idx_d;
   logic              cmp_vld_q, cmp_vld_d;
   logic [7:0]        line_q, line_d;

   logic [CntW-1:0]   back_cnt_q, back_cnt_d;
   logic              back_ovf_q, back_ovf_d;
   logic [31:0]       back_obj_q [MaxPerLine];
   logic [31:0]       back_obj_d [MaxPerLine];
   logic [2:0]        back_row_q [MaxPerLine];
   logic [2:0]        back_row_d [MaxPerLine];

   logic [CntW-1:0]   front_cnt_q, front_cnt_d;
   logic              front_ovf_q, front_ovf_d;
   logic [31:0]       front_obj_q [MaxPerLine];
   logic [31:0]       front_obj_d [MaxPerLine];
   logic [2:0]        front_row_q [MaxPerLine];
   logic [2:0]        front_row_d [MaxPerLine];

   logic [7:0]        diff;
   logic [2:0]        row;
   logic              obj_hit;
   logic              bank_full;
   logic              ovf_now;
   logic              slot_valid;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_idx_d  = last_idx_q;
      line_d      = line_q;
      back_cnt_d  = back_cnt_q;
      back_ovf_d  = back_ovf_q;
      back_obj_d  = back_obj_q;
      back_row_d  = back_row_q;
      front_cnt_d = front_cnt_q;
      front_ovf_d = front_ovf_q;
      front_obj_d = front_obj_q;
      front_row_d = front_row_q;
      obm_re_o    = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;

      // Modular difference makes objects near y=255 wrap onto the top lines.
      diff      = line_q - obm_object_i[YMsb:YLsb];
      obj_hit   = cmp_vld_q && (diff[7:RowW] == '0);
      row       = obm_object_i[VflipBit] ? ~diff[2:0] : diff[2:0];
      bank_full = (back_cnt_q == CntW'(MaxPerLine));
      ovf_now   = obj_hit && bank_full;

      if (obj_hit) begin
         if (bank_full) begin
            back_ovf_d = 1'b1;
         end else begin
            back_obj_d[back_cnt_q[SlotW-1:0]] = obm_object_i;
            back_row_d[back_cnt_q[SlotW-1:0]] = row;
            back_cnt_d = back_cnt_q + CntW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_FETCH;
               idx_d   = '0;
               line_d  = line_i;
            end
         end
         S_FETCH: begin
            busy_o = 1'b1;
            // An overflowing hit suppresses the read that would otherwise go out this cycle.
            if (ovf_now) begin
               state_d = S_DONE;
            end else begin
               obm_re_o   = 1'b1;
               last_idx_d = idx_q;
               if (idx_q == IdxW'(NumObjects - 1)) begin
                  state_d = S_DRAIN;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         S_DRAIN: begin
            busy_o  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      cmp_vld_d = obm_re_o;

      // Swap on the edge entering DONE so the front bank is already new while done_o is high.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         front_cnt_d = back_cnt_d;
         front_ovf_d = back_ovf_d;
         front_obj_d = back_obj_d;
         front_row_d = back_row_d;
         back_cnt_d  = '0;
         back_ovf_d  = 1'b0;
         for (int i = 0; i < MaxPerLine; i++) begin
            back_obj_d[i] = '0;
            back_row_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_gpu or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         last_idx_q  <= '0;
         cmp_vld_q   <= 1'b0;
         line_q      <= '0;
         back_cnt_q  <= '0;
         back_ovf_q  <= 1'b0;
         front_cnt_q <= '0;
         front_ovf_q <= 1'b0;
         for (int i = 0; i < MaxPerLine; i++) begin
            back_obj_q[i]  <= '0;
            back_row_q[i]  <= '0;
            front_obj_q[i] <= '0;
            front_row_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_idx_q  <= last_idx_d;
         cmp_vld_q   <= cmp_vld_d;
         line_q      <= line_d;
         back_cnt_q  <= back_cnt_d;
         back_ovf_q  <= back_ovf_d;
         back_obj_q  <= back_obj_d;
         back_row_q  <= back_row_d;
         front_cnt_q <= front_cnt_d;
         front_ovf_q <= front_ovf_d;
         front_obj_q <= front_obj_d;
         front_row_q <= front_row_d;
      end
   end

   assign obm_index_o   = obm_re_o ? idx_q : last_idx_q;
   assign hit_count_o   = front_cnt_q;
   assign overflow_o    = front_ovf_q;
   assign slot_valid    = ({1'b0, slot_sel_i} < front_cnt_q);
   assign slot_object_o = slot_valid ? front_obj_q[slot_sel_i] : '0;
   assign slot_row_o    = slot_valid ? front_row_q[slot_sel_i] : '0;

endmodule

// File: tb/tb_gpu_foreground_line_scanner.sv
// Directed bench for gpu_foreground_line_scanner: a list-level scan model plus per-cycle comparison
// and hand-computed expectations for the documented scenarios.
module tb_gpu_foreground_line_scanner;

   localparam int NO  = 64;
   localparam int MPL = 8;

   logic        clk_gpu;
   logic        rst_n;
   logic        start_i;
   logic [7:0]  line_i;
   logic        obm_re_o;
   logic [5:0]  obm_index_o;
   logic [31:0] obm_object_i;
   logic        busy_o;
   logic        done_o;
   logic [3:0]  hit_count_o;
   logic        overflow_o;
   logic [2:0]  slot_sel_i;
   logic [31:0] slot_object_o;
   logic [2:0]  slot_row_o;

   gpu_foreground_line_scanner dut (
      .clk_gpu      (clk_gpu),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .line_i       (line_i),
      .obm_re_o     (obm_re_o),
      .obm_index_o  (obm_index_o),
      .obm_object_i (obm_object_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .hit_count_o  (hit_count_o),
      .overflow_o   (overflow_o),
      .slot_sel_i   (slot_sel_i),
      .slot_object_o(slot_object_o),
      .slot_row_o   (slot_row_o)
   );

   initial clk_gpu = 1'b0;
   always #5 clk_gpu = ~clk_gpu;

   logic [31:0] mem [NO];

   // Object layout: [23:16] y, [13:8] tag, [0] vflip; upper byte is a marker.
   function automatic logic [31:0] mk(input int y, input bit vf, input int tag);
      logic [7:0] yb;
      logic [5:0] tb6;
      yb  = y[7:0];
      tb6 = tag[5:0];
      return {8'hA0, yb, 2'b00, tb6, 7'd0, vf};
   endfunction

   // OBM: data one cycle after the read strobe; junk otherwise.
   always @(posedge clk_gpu) begin
      if (obm_re_o) obm_object_i <= mem[obm_index_o];
      else          obm_object_i <= 32'h5A0A_0F01;
   end

   // Scan model: the expected hit list is computed from the OBM contents when the start is accepted.
   bit          m_busy;
   int          m_cyc, m_done_cyc, m_last_issue;
   int          p_cnt;
   bit          p_ovf;
   logic [31:0] p_obj [MPL];
   int          p_row [MPL];
   int          f_cnt;
   bit          f_ovf;
   logic [31:0] f_obj [MPL];
   int          f_row [MPL];

   always @(posedge clk_gpu) begin
      if (!rst_n) begin
         m_busy = 0; m_cyc = 0; f_cnt = 0; f_ovf = 0;
         for (int i = 0; i < MPL; i++) begin f_obj[i] = '0; f_row[i] = 0; end
      end else if (m_busy) begin
         if (m_cyc == m_done_cyc) m_busy = 0;
         else begin
            m_cyc++;
            if (m_cyc == m_done_cyc) begin
               f_cnt = p_cnt; f_ovf = p_ovf;
               for (int i = 0; i < MPL; i++) begin f_obj[i] = p_obj[i]; f_row[i] = p_row[i]; end
            end
         end
      end else if (start_i) begin
         int d, klast;
         m_busy = 1; m_cyc = 1;
         p_cnt = 0; p_ovf = 0; klast = NO - 1;
         for (int i = 0; i < MPL; i++) begin p_obj[i] = '0; p_row[i] = 0; end
         for (int k = 0; k < NO; k++) begin
            d = int'(line_i) - int'(mem[k][23:16]);
            if (d < 0) d += 256;
            if (d < 8) begin
               if (p_cnt == MPL) begin p_ovf = 1; klast = k; break; end
               p_obj[p_cnt] = mem[k];
               p_row[p_cnt] = mem[k][0] ? 7 - d : d;
               p_cnt++;
            end
         end
         m_done_cyc   = klast + 3;
         m_last_issue = p_ovf ? klast : NO - 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int m_idx_hold = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_cycle();
      bit          exp_re;
      logic [31:0] eo;
      int          er;
      if (!rst_n) begin
         m_idx_hold = 0;
         return;
      end
      exp_re = m_busy && (m_cyc - 1 <= m_last_issue);
      if (exp_re) m_idx_hold = m_cyc - 1;
      eo = (int'(slot_sel_i) < f_cnt) ? f_obj[slot_sel_i] : 32'd0;
      er = (int'(slot_sel_i) < f_cnt) ? f_row[slot_sel_i] : 0;
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_busy && (m_cyc == m_done_cyc));
      chk("obm_re", obm_re_o, exp_re);
      chk("obm_index", obm_index_o, m_idx_hold);
      chk("hit_count", hit_count_o, f_cnt);
      chk("overflow", overflow_o, f_ovf);
      chk("slot_object", slot_object_o, eo);
      chk("slot_row", slot_row_o, er);
   endtask

   task automatic tick();
      @(negedge clk_gpu);
      cmp_cycle();
   endtask

   task automatic read_slot(input int sel, output logic [31:0] obj, output int row);
      #2 slot_sel_i = sel[2:0];
      #1 obj = slot_object_o;
      row = int'(slot_row_o);
   endtask

   task automatic fill_bg();
      for (int k = 0; k < NO; k++) mem[k] = mk(200, 0, k);
   endtask

   task automatic run_scan(input int line, input int poke_cyc, input bit start_in_done,
                           output int dcyc, output int maxidx, output int nreads);
      start_i = 1; line_i = line[7:0];
      tick();
      start_i = 0;
      dcyc = -1; maxidx = 0; nreads = 0;
      for (int c = 1; c <= 200; c++) begin
         if (obm_re_o) begin
            nreads++;
            if (int'(obm_index_o) > maxidx) maxidx = int'(obm_index_o);
         end
         if (done_o) begin dcyc = c; break; end
         start_i = (c == poke_cyc);
         if (c == poke_cyc) line_i = 8'd77;
         tick();
      end
      start_i = 0;
      if (dcyc < 0) chk("done_timeout", 0, 1);
      if (start_in_done) begin
         start_i = 1; line_i = 8'd4;
         tick();
         start_i = 0;
      end
      tick();
   endtask

   initial begin
      int          dc, mx, nr, row;
      logic [31:0] obj;
      rst_n = 0; start_i = 0; line_i = 0; slot_sel_i = 0;
      fill_bg();
      tick(); tick();
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_re", obm_re_o, 0);
      chk("rst_index", obm_index_o, 0);
      chk("rst_count", hit_count_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_slot", slot_object_o, 0);
      rst_n = 1;
      tick();

      // 1: nothing on the line, full 64-entry walk
      run_scan(10, 0, 0, dc, mx, nr);
      chk("t1_done_cyc", dc, 66);
      chk("t1_maxidx", mx, 63);
      chk("t1_nreads", nr, 64);
      chk("t1_count", hit_count_o, 0);
      chk("t1_ovf", overflow_o, 0);

      // 2: two hits in index order, one miss from modular difference
      mem[5] = mk(10, 0, 5); mem[9] = mk(3, 0, 9); mem[40] = mk(17, 0, 40);
      run_scan(10, 0, 0, dc, mx, nr);
      chk("t2_count", hit_count_o, 2);
      read_slot(0, obj, row);
      chk("t2_slot0_obj", obj, 32'hA00A_0500);
      chk("t2_slot0_row", row, 0);
      read_slot(1, obj, row);
      chk("t2_slot1_obj", obj, 32'hA003_0900);
      chk("t2_slot1_row", row, 7);
      read_slot(2, obj, row);
      chk("t2_slot2_empty", obj, 0);
      tick();

      // 3: vertical flip
      fill_bg(); mem[0] = mk(8, 1, 0);
      run_scan(10, 0, 0, dc, mx, nr);
      read_slot(0, obj, row);
      chk("t3_vflip_row", row, 5);
      mem[0] = mk(8, 0, 0);
      run_scan(10, 0, 0, dc, mx, nr);
      read_slot(0, obj, row);
      chk("t3_noflip_row", row, 2);
      tick();

      // 4: overflow after eight hits
      fill_bg();
      for (int k = 0; k < 10; k++) mem[k] = mk(0, 0, k);
      slot_sel_i = 0;
      run_scan(4, 0, 0, dc, mx, nr);
      chk("t4_done_cyc", dc, 11);
      chk("t4_maxidx", mx, 8);
      chk("t4_count", hit_count_o, 8);
      chk("t4_ovf", overflow_o, 1);
      read_slot(7, obj, row);
      chk("t4_slot7_obj", obj, 32'hA000_0700);
      chk("t4_slot7_row", row, 4);
      tick();

      // 5: wrap at the bottom of the y range
      fill_bg(); mem[3] = mk(252, 0, 3);
      slot_sel_i = 0;
      run_scan(2, 0, 0, dc, mx, nr);
      chk("t5_count", hit_count_o, 1);
      read_slot(0, obj, row);
      chk("t5_row", row, 6);
      run_scan(4, 0, 0, dc, mx, nr);
      chk("t5_miss_count", hit_count_o, 0);

      // 6: bank stability, ignored starts, reset mid-scan
      fill_bg();
      mem[5] = mk(10, 0, 5); mem[9] = mk(3, 0, 9);
      slot_sel_i = 1;
      run_scan(10, 0, 0, dc, mx, nr);
      chk("t6_a_count", hit_count_o, 2);
      run_scan(100, 30, 1, dc, mx, nr);
      chk("t6_b_done_cyc", dc, 66);
      chk("t6_b_count", hit_count_o, 0);
      run_scan(10, 0, 0, dc, mx, nr);
      chk("t6_a2_count", hit_count_o, 2);
      start_i = 1; line_i = 8'd10;
      tick();
      start_i = 0;
      repeat (20) tick();
      chk("t6_busy_before_rst", busy_o, 1);
      rst_n = 0;
      #1;
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_count", hit_count_o, 0);
      chk("t6_rst_done", done_o, 0);
      tick(); tick();
      rst_n = 1;
      nr = 0;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (done_o) nr++;
      end
      chk("t6_no_done_after_rst", nr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
